// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD stream decoder.
// Optional macro BCD_CLAMP_EN selects clamping of invalid nibbles to 9.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        FINISH
    } state_t;

    localparam int ONEHOT_W = 10;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_is_valid(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_nibble_decode.sv
// Combinational nibble to 10-line one-hot decoder with invalid flag.
// Macro BCD_CLAMP_EN: invalid nibbles decode as digit 9 instead of zero lines.
module bcd_nibble_decode
    import bcd_pkg::*;
(
    input  logic [3:0]          nib,
    output logic [ONEHOT_W-1:0] onehot,
    output logic [3:0]          val,
    output logic                invalid
);

    always_comb begin
        invalid = !bcd_is_valid(nib);
        onehot  = '0;
        val     = '0;
        if (!invalid) begin
            onehot = ONEHOT_W'(1) << nib;
            val    = nib;
        end else begin
`ifdef BCD_CLAMP_EN
            onehot = ONEHOT_W'(1) << BCD_MAX;
            val    = BCD_MAX;
`else
            onehot = '0;
            val    = '0;
`endif
        end
    end

endmodule

// File: rtl/bcd_stream_decoder.sv
// Walks a packed BCD word MSD first, emitting one-hot digits and the binary value.
// Macro BCD_CLAMP_EN (see bcd_nibble_decode) changes invalid-nibble handling.
module bcd_stream_decoder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_bcd,
    output logic                dig_valid,
    output logic [ONEHOT_W-1:0] dig_onehot,
    output logic [2:0]          dig_idx,
    output logic                dig_err,
    output logic                done,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err
);

    localparam int IN_W  = 4 * DIGITS;
    localparam int ACC_W = BIN_W + 4;

    state_t              state_q, state_d;
    logic [IN_W-1:0]     sr_q, sr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                err_acc_q, err_acc_d;
    logic                dig_valid_q, dig_valid_d;
    logic [ONEHOT_W-1:0] dig_onehot_q, dig_onehot_d;
    logic [2:0]          dig_idx_q, dig_idx_d;
    logic                dig_err_q, dig_err_d;
    logic                done_q, done_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                err_q, err_d;

    logic [ONEHOT_W-1:0] nib_onehot;
    logic [3:0]          nib_val;
    logic                nib_err;

    bcd_nibble_decode u_dec (
        .nib     (sr_q[IN_W-1 -: 4]),
        .onehot  (nib_onehot),
        .val     (nib_val),
        .invalid (nib_err)
    );

    // The done cycle is still part of the word, so IDLE only opens after it.
    assign in_ready   = (state_q == IDLE) && !done_q && !rst;
    assign dig_valid  = dig_valid_q;
    assign dig_onehot = dig_onehot_q;
    assign dig_idx    = dig_idx_q;
    assign dig_err    = dig_err_q;
    assign done       = done_q;
    assign bin_out    = bin_q;
    assign err        = err_q;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        err_acc_d    = err_acc_q;
        dig_valid_d  = 1'b0;
        dig_onehot_d = dig_onehot_q;
        dig_idx_d    = dig_idx_q;
        dig_err_d    = dig_err_q;
        done_d       = 1'b0;
        bin_d        = bin_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sr_d      = in_bcd;
                    cnt_d     = 3'(DIGITS - 1);
                    acc_d     = '0;
                    err_acc_d = 1'b0;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                dig_valid_d  = 1'b1;
                dig_onehot_d = nib_onehot;
                dig_idx_d    = cnt_q;
                dig_err_d    = nib_err;
                acc_d        = acc_q * ACC_W'(10) + ACC_W'(nib_val);
                err_acc_d    = err_acc_q | nib_err;
                sr_d         = sr_q << 4;
                if (cnt_q == 3'd0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                bin_d   = acc_q[BIN_W-1:0];
                err_d   = err_acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            err_acc_q    <= 1'b0;
            dig_valid_q  <= 1'b0;
            dig_onehot_q <= '0;
            dig_idx_q    <= '0;
            dig_err_q    <= 1'b0;
            done_q       <= 1'b0;
            bin_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            err_acc_q    <= err_acc_d;
            dig_valid_q  <= dig_valid_d;
            dig_onehot_q <= dig_onehot_d;
            dig_idx_q    <= dig_idx_d;
            dig_err_q    <= dig_err_d;
            done_q       <= done_d;
            bin_q        <= bin_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_stream_decoder.sv
// Directed bench for bcd_stream_decoder (DIGITS=4, BIN_W=14).
module tb_bcd_stream_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        dig_valid;
    logic [9:0]  dig_onehot;
    logic [2:0]  dig_idx;
    logic        dig_err;
    logic        done;
    logic [13:0] bin_out;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;

    bcd_stream_decoder #(.DIGITS(4), .BIN_W(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bcd     (in_bcd),
        .dig_valid  (dig_valid),
        .dig_onehot (dig_onehot),
        .dig_idx    (dig_idx),
        .dig_err    (dig_err),
        .done       (done),
        .bin_out    (bin_out),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_word(input string nm, input logic [15:0] w,
                            input logic [39:0] oh, input logic [3:0] derr,
                            input logic [13:0] bin, input logic e);
        in_bcd   = w;
        in_valid = 1'b1;
        chk({nm, "_ready_pre"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_bcd   = 16'hFFFF;
        chk({nm, "_ready_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_dv%0d", nm, i), 32'(dig_valid), 32'd1);
            chk($sformatf("%s_oh%0d", nm, i), 32'(dig_onehot),
                32'(oh[(3-i)*10 +: 10]));
            chk($sformatf("%s_idx%0d", nm, i), 32'(dig_idx), 32'(3 - i));
            chk($sformatf("%s_derr%0d", nm, i), 32'(dig_err),
                32'(derr[3-i]));
            chk($sformatf("%s_nodone%0d", nm, i), 32'(done), 32'd0);
        end
        tick();
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_bin"}, 32'(bin_out), 32'(bin));
        chk({nm, "_err"}, 32'(err), 32'(e));
        chk({nm, "_dv_fin"}, 32'(dig_valid), 32'd0);
        chk({nm, "_ready_fin"}, 32'(in_ready), 32'd0);
        tick();
        chk({nm, "_done_drop"}, 32'(done), 32'd0);
        chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
        chk({nm, "_bin_hold"}, 32'(bin_out), 32'(bin));
    endtask

    initial begin
        int low_cnt;
        int done_cnt;
        logic [13:0] first_bin;
        logic saw;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_bcd   = 16'h0000;
        tick();
        tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_dv", 32'(dig_valid), 32'd0);
        chk("rst_oh", 32'(dig_onehot), 32'd0);
        chk("rst_idx", 32'(dig_idx), 32'd0);
        chk("rst_derr", 32'(dig_err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        run_word("w1234", 16'h1234, {10'h002, 10'h004, 10'h008, 10'h010},
                 4'b0000, 14'd1234, 1'b0);
        run_word("w9999", 16'h9999, {10'h200, 10'h200, 10'h200, 10'h200},
                 4'b0000, 14'd9999, 1'b0);
`ifdef BCD_CLAMP_EN
        run_word("w12A4", 16'h12A4, {10'h002, 10'h004, 10'h200, 10'h010},
                 4'b0010, 14'd1294, 1'b1);
`else
        run_word("w12A4", 16'h12A4, {10'h002, 10'h004, 10'h000, 10'h010},
                 4'b0010, 14'd1204, 1'b1);
`endif

        // Back-to-back: in_valid held, word changes right after acceptance
        in_bcd   = 16'h0000;
        in_valid = 1'b1;
        tick();
        in_bcd    = 16'h0001;
        low_cnt   = 0;
        saw       = 1'b0;
        first_bin = 14'h3FFF;
        while (!in_ready && low_cnt < 20) begin
            if (done) begin
                saw       = 1'b1;
                first_bin = bin_out;
            end
            low_cnt++;
            tick();
        end
        chk("b2b_low_cycles", 32'(low_cnt), 32'd6);
        chk("b2b_done0", 32'(saw), 32'd1);
        chk("b2b_bin0", 32'(first_bin), 32'd0);
        tick();
        in_valid = 1'b0;
        saw      = 1'b0;
        for (int i = 0; i < 10 && !saw; i++) begin
            tick();
            if (done) saw = 1'b1;
        end
        chk("b2b_done1", 32'(saw), 32'd1);
        chk("b2b_bin1", 32'(bin_out), 32'd1);
        chk("b2b_err1", 32'(err), 32'd0);
        tick();

        // Reset in the middle of 5678
        in_bcd   = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_dv_before", 32'(dig_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_dv", 32'(dig_valid), 32'd0);
        chk("mid_bin", 32'(bin_out), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd1);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("mid_no_done", 32'(done_cnt), 32'd0);
        run_word("w0042", 16'h0042, {10'h001, 10'h001, 10'h010, 10'h004},
                 4'b0000, 14'd42, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_stream_decoder.md
Name: bcd_stream_decoder

Overview:
- Decode direction of the team's 10-line-to-BCD priority encoders.
- Accepts a packed multi-digit BCD word over a valid/ready handshake.
- Walks the word one digit per cycle, most significant digit first. Each digit is emitted as a 10-line one-hot code (line k high for digit k).
- Also accumulates the binary value of the word and flags non-BCD nibbles (0xA to 0xF). Sits between BCD-producing logic and display or arithmetic consumers.

Parameters:
- DIGITS, 4, number of BCD digits in in_bcd; legal range 1 to 8.
- BIN_W, 14, width of bin_out. Must be at least ceil(log2(10^DIGITS)); if smaller, the result is truncated modulo 2^BIN_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bcd holds a word to decode.
- in_ready  output  1  block can accept a word (IDLE only).
- in_bcd  input  4*DIGITS  packed BCD; nibble DIGITS-1 is the most significant.
- dig_valid  output  1  dig_onehot and dig_idx are valid this cycle.
- dig_onehot  output  10  one-hot decoded digit; bit k means digit value k.
- dig_idx  output  3  position of the current digit (DIGITS-1 down to 0).
- dig_err  output  1  current nibble is not BCD.
- done  output  1  one-cycle pulse; bin_out and err are updated.
- bin_out  output  BIN_W  binary value of the last completed word; held until the next done.
- err  output  1  at least one invalid nibble in the last completed word; held with bin_out.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: in_ready=0 while rst is high. dig_valid, dig_onehot, dig_idx, dig_err, done, bin_out and err are all 0. State is IDLE.
- All outputs are registered; in_ready decodes the state register directly.
- FSM states: IDLE, DECODE, FINISH.
- IDLE: in_ready=1. When in_valid and in_ready are both high at an edge:
  - latch in_bcd into a shift register;
  - set cnt=DIGITS-1, acc=0, err_acc=0;
  - go to DECODE.
- DECODE: each cycle, decode nibble cnt.
  - Next edge registers dig_valid=1, dig_onehot, dig_idx=cnt, dig_err.
  - acc <= acc*10 + digit value, with width BIN_W+4 internally and truncation on the final load.
  - err_acc |= invalid.
  - When cnt==0, go to FINISH; otherwise cnt decrements.
- FINISH: for one cycle, done=1, bin_out<=acc[BIN_W-1:0], err<=err_acc, dig_valid=0; then go to IDLE.
- Timing: if a word is accepted at edge t, digits appear at edges t+1 to t+DIGITS, done is high after edge t+DIGITS+1, and in_ready returns after edge t+DIGITS+2. Throughput is one word per DIGITS+2 cycles.
- Invalid nibble (default build): dig_onehot=0, dig_err=1, and the digit contributes 0 to acc.
- in_valid while busy: ignored (in_ready=0). The sender holds the word, and it is accepted in the next IDLE cycle.
- in_bcd changing after acceptance has no effect.
- Reset mid-word: the word is aborted and done does not pulse. bin_out and err return to 0. in_ready=1 in the first cycle after rst falls.
- DIGITS=1: a single digit cycle, then FINISH.

Optional Feature:
- Macro: BCD_CLAMP_EN.
- Defined: an invalid nibble is clamped to 9. dig_onehot=10'h200, the digit contributes 9 to acc, and dig_err and err are still flagged.
- Undefined: default invalid-nibble handling as described above.

Decomposition:
- Package bcd_pkg contains:
  - state typedef (IDLE, DECODE, FINISH);
  - constant ONEHOT_W=10;
  - constant BCD_MAX=9;
  - function bcd_is_valid(nibble).
- Sub-module bcd_nibble_decode: combinational, 4-bit nibble in, 10-bit one-hot plus invalid flag out, honouring BCD_CLAMP_EN. Instantiated once; the sequential walk stays in the top module.

Test Plan:
- Normal word: DIGITS=4, in_bcd=16'h1234, accepted at t.
  - dig_onehot is 10'h002, 10'h004, 10'h008, 10'h010 at t+1 to t+4, with dig_idx 3, 2, 1, 0.
  - done at t+5 with bin_out=1234 (0x04D2) and err=0.
- Maximum value: in_bcd=16'h9999 gives dig_onehot=10'h200 on all four digits, bin_out=9999 (0x270F), err=0.
- Invalid nibble: in_bcd=16'h12A4.
  - Digit 1 has dig_err=1 and dig_onehot=0; bin_out=1204 and err=1.
  - With BCD_CLAMP_EN: dig_onehot=10'h200 and bin_out=1294, err=1.
- Back-to-back words: in_valid held high with 16'h0000, then 16'h0001.
  - in_ready is low for 6 cycles between acceptances.
  - The done pulses report bin_out 0, then 1.
- Reset mid-word: rst for one cycle at t+2 during 16'h5678.
  - dig_valid=0 after that edge, done never pulses, bin_out=0.
  - in_ready=1 in the next cycle; a fresh 16'h0042 then gives bin_out=42.
